// File: rtl/pipeline_register_fd_elastic.sv
// pipeline_register_fd_elastic: elastic fetch/decode register with skid entry, flush and a bubble counter.
module pipeline_register_fd_elastic #(
  parameter int INSTR_W = 18,
  parameter int PC_W = 16,
  parameter int OPCODE_W = 6,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W = 4,
  parameter int JUMP_W = 12,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  f_valid,
  output logic                  f_ready,
  input  logic [INSTR_W-1:0]    f_instruction,
  input  logic [PC_W-1:0]       f_pc_inc,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [INSTR_W-1:0]    d_instruction,
  output logic [PC_W-1:0]       d_pc_inc,
  output logic [OPCODE_W-1:0]   d_opcode,
  output logic [REG_ADDR_W-1:0] d_address1,
  output logic [REG_ADDR_W-1:0] d_address2,
  output logic [IMM_W-1:0]      d_immediate,
  output logic [JUMP_W-1:0]     d_jumpaddress,
  output logic [CNT_W-1:0]      d_bubbles
);
  if (OPCODE_W + 2*REG_ADDR_W + IMM_W != INSTR_W || JUMP_W > INSTR_W - OPCODE_W) begin : g_bad_cfg
    $error("pipeline_register_fd_elastic: illegal field widths");
  end
  localparam int A1_HI = INSTR_W - OPCODE_W - 1;
  localparam int A2_HI = A1_HI - REG_ADDR_W;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic f_ready_q, f_ready_d, accept, consume;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [REG_ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [JUMP_W-1:0] jump_q, jump_d;
  logic [CNT_W-1:0] bubbles_q, bubbles_d;
  assign d_valid = state_q != EMPTY;
  assign f_ready = f_ready_q;
  assign d_instruction = main_instr_q;
  assign d_pc_inc = main_pc_q;
  assign d_opcode = opcode_q;
  assign d_address1 = addr1_q;
  assign d_address2 = addr2_q;
  assign d_immediate = imm_q;
  assign d_jumpaddress = jump_q;
  assign d_bubbles = bubbles_q;
  always_comb begin
    accept = f_valid & f_ready_q;
    consume = d_valid & d_ready;
    state_d = state_q;
    main_instr_d = main_instr_q;
    main_pc_d = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d = EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc_d = '0;
      skid_instr_d = '0;
      skid_pc_d = '0;
    end else if (state_q == EMPTY) begin
      if (accept) begin
        state_d = ONE;
        main_instr_d = f_instruction;
        main_pc_d = f_pc_inc;
      end
    end else if (state_q == ONE) begin
      if (consume && accept) begin
        main_instr_d = f_instruction;
        main_pc_d = f_pc_inc;
      end else if (consume) begin
        state_d = EMPTY;
        main_instr_d = NOP_INSTR;
        main_pc_d = '0;
      end else if (accept) begin
        state_d = TWO;
        skid_instr_d = f_instruction;
        skid_pc_d = f_pc_inc;
      end
    end else if (consume) begin
      state_d = ONE;
      main_instr_d = skid_instr_q;
      main_pc_d = skid_pc_q;
    end
    f_ready_d = state_d != TWO;
    // fields are split here so the DECODE outputs come straight from flops
    opcode_d = main_instr_d[INSTR_W-1 -: OPCODE_W];
    addr1_d = main_instr_d[A1_HI -: REG_ADDR_W];
    addr2_d = main_instr_d[A2_HI -: REG_ADDR_W];
    imm_d = main_instr_d[IMM_W-1:0];
    jump_d = main_instr_d[JUMP_W-1:0];
    bubbles_d = (!d_valid && !flush && bubbles_q != '1) ? bubbles_q + 1'b1 : bubbles_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      f_ready_q <= 1'b1;
      main_instr_q <= NOP_INSTR;
      main_pc_q <= '0;
      skid_instr_q <= '0;
      skid_pc_q <= '0;
      opcode_q <= NOP_INSTR[INSTR_W-1 -: OPCODE_W];
      addr1_q <= NOP_INSTR[A1_HI -: REG_ADDR_W];
      addr2_q <= NOP_INSTR[A2_HI -: REG_ADDR_W];
      imm_q <= NOP_INSTR[IMM_W-1:0];
      jump_q <= NOP_INSTR[JUMP_W-1:0];
      bubbles_q <= '0;
    end else begin
      state_q <= state_d;
      f_ready_q <= f_ready_d;
      main_instr_q <= main_instr_d;
      main_pc_q <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
      opcode_q <= opcode_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      imm_q <= imm_d;
      jump_q <= jump_d;
      bubbles_q <= bubbles_d;
    end
  end
endmodule

// File: tb/tb_pipeline_register_fd_elastic.sv
// tb_pipeline_register_fd_elastic: directed + random checks of two configurations against a FIFO reference model.
module tb_pipeline_register_fd_elastic;
  localparam int AIW = 18, AOW = 6, ARW = 4, AMW = 4, AJW = 12;
  localparam int BIW = 24, BOW = 8, BRW = 5, BMW = 6, BJW = 16;
  localparam logic [23:0] B_NOP = 24'hFF0000;
  logic clk = 0, reset = 1, flush = 0, f_valid = 0, d_ready = 0;
  logic [17:0] a_fi = '0;
  logic [23:0] b_fi = '0;
  logic [15:0] f_pc = '0;
  logic a_fr, a_dv, b_fr, b_dv;
  logic [17:0] a_di;
  logic [23:0] b_di;
  logic [15:0] a_pc, b_pc, b_bub;
  logic [5:0] a_op;
  logic [3:0] a_a1, a_a2, a_imm;
  logic [11:0] a_jmp;
  logic [2:0] a_bub;
  logic [7:0] b_op;
  logic [4:0] b_a1, b_a2;
  logic [5:0] b_imm;
  logic [15:0] b_jmp;
  int nvec = 0, nerr = 0;
  typedef struct {logic [17:0] a; logic [23:0] b; logic [15:0] pc;} ent_t;
  ent_t q[$];
  bit mf_ready = 1;
  int bub_a = 0, bub_b = 0;

  always #5 clk = ~clk;

  pipeline_register_fd_elastic #(.CNT_W(3)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .f_valid(f_valid), .f_ready(a_fr),
    .f_instruction(a_fi), .f_pc_inc(f_pc), .d_valid(a_dv), .d_ready(d_ready),
    .d_instruction(a_di), .d_pc_inc(a_pc), .d_opcode(a_op), .d_address1(a_a1),
    .d_address2(a_a2), .d_immediate(a_imm), .d_jumpaddress(a_jmp), .d_bubbles(a_bub));

  pipeline_register_fd_elastic #(.INSTR_W(24), .OPCODE_W(8), .REG_ADDR_W(5), .IMM_W(6),
    .JUMP_W(16), .NOP_INSTR(B_NOP)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .f_valid(f_valid), .f_ready(b_fr),
    .f_instruction(b_fi), .f_pc_inc(f_pc), .d_valid(b_dv), .d_ready(d_ready),
    .d_instruction(b_di), .d_pc_inc(b_pc), .d_opcode(b_op), .d_address1(b_a1),
    .d_address2(b_a2), .d_immediate(b_imm), .d_jumpaddress(b_jmp), .d_bubbles(b_bub));

  function automatic logic [63:0] fld(logic [63:0] v, int lsb, int w);
    return (v >> lsb) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one rising edge of the reference: FIFO of at most two entries
  task automatic model_edge();
    bit acc;
    if (reset) begin
      q.delete();
      mf_ready = 1;
      bub_a = 0;
      bub_b = 0;
      return;
    end
    if (q.size() == 0 && !flush) begin
      bub_a = (bub_a < 7) ? bub_a + 1 : 7;
      bub_b = (bub_b < 65535) ? bub_b + 1 : 65535;
    end
    if (flush) q.delete();
    else begin
      acc = f_valid && mf_ready;
      if (q.size() > 0 && d_ready) void'(q.pop_front());
      if (acc) q.push_back('{a: a_fi, b: b_fi, pc: f_pc});
    end
    mf_ready = q.size() < 2;
  endtask

  task automatic check_all();
    logic [63:0] ea, eb, ep;
    bit v;
    v = q.size() > 0;
    ea = v ? 64'(q[0].a) : 64'd0;
    eb = v ? 64'(q[0].b) : 64'(B_NOP);
    ep = v ? 64'(q[0].pc) : 64'd0;
    chk("a_d_valid", 64'(a_dv), 64'(v));
    chk("a_f_ready", 64'(a_fr), 64'(mf_ready));
    chk("a_instr", 64'(a_di), ea);
    chk("a_pc", 64'(a_pc), ep);
    chk("a_opcode", 64'(a_op), fld(ea, AIW-AOW, AOW));
    chk("a_addr1", 64'(a_a1), fld(ea, AIW-AOW-ARW, ARW));
    chk("a_addr2", 64'(a_a2), fld(ea, AIW-AOW-2*ARW, ARW));
    chk("a_imm", 64'(a_imm), fld(ea, 0, AMW));
    chk("a_jump", 64'(a_jmp), fld(ea, 0, AJW));
    chk("a_bubbles", 64'(a_bub), 64'(bub_a));
    chk("b_d_valid", 64'(b_dv), 64'(v));
    chk("b_f_ready", 64'(b_fr), 64'(mf_ready));
    chk("b_instr", 64'(b_di), eb);
    chk("b_pc", 64'(b_pc), ep);
    chk("b_opcode", 64'(b_op), fld(eb, BIW-BOW, BOW));
    chk("b_addr1", 64'(b_a1), fld(eb, BIW-BOW-BRW, BRW));
    chk("b_addr2", 64'(b_a2), fld(eb, BIW-BOW-2*BRW, BRW));
    chk("b_imm", 64'(b_imm), fld(eb, 0, BMW));
    chk("b_jump", 64'(b_jmp), fld(eb, 0, BJW));
    chk("b_bubbles", 64'(b_bub), 64'(bub_b));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic offer(logic v, logic [17:0] a, logic [15:0] pc);
    f_valid = v;
    a_fi = a;
    b_fi = 24'($urandom);
    f_pc = pc;
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    // streaming
    d_ready = 1;
    offer(1, 18'h0B2C5, 16'h0001); tick();
    offer(1, 18'h3F123, 16'h0002); tick();
    offer(0, 18'h15555, 16'h0003); tick();
    tick();
    // skid: A in main, then B into skid, C held off
    offer(1, 18'h0AAAA, 16'h0010); tick();
    d_ready = 0;
    offer(1, 18'h0BBBB, 16'h0011); tick();
    offer(1, 18'h0CCCC, 16'h0012); tick();
    tick();
    d_ready = 1; tick();
    tick();
    offer(0, 18'h0, 16'h0); tick();
    tick();
    // flush in TWO with a simultaneous offer
    d_ready = 0;
    offer(1, 18'h11111, 16'h0020); tick();
    offer(1, 18'h22222, 16'h0021); tick();
    flush = 1;
    offer(1, 18'h0DDDD, 16'h0022); tick();
    flush = 0;
    d_ready = 1;
    offer(1, 18'h0EEEE, 16'h0023); tick();
    offer(0, 18'h0, 16'h0); tick();
    tick();
    // bubble counter saturation, flush cycles excluded
    #2 reset = 1;
    #1 model_edge();
    check_all();
    #2 reset = 0;
    tick();
    tick();
    flush = 1; tick();
    tick();
    flush = 0;
    for (int i = 0; i < 10; i++) tick();
    // asynchronous reset between edges while in TWO
    d_ready = 0;
    offer(1, 18'h12345, 16'h0030); tick();
    offer(1, 18'h2ABCD, 16'h0031); tick();
    offer(0, 18'h0, 16'h0);
    #2 reset = 1;
    #1 model_edge();
    check_all();
    tick();
    reset = 0;
    tick();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      f_valid = $urandom_range(0, 3) != 0;
      d_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      a_fi = 18'($urandom);
      b_fi = 24'($urandom);
      f_pc = 16'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
